// File: rtl/mul_sequencer_if.sv
// rtl/mul_sequencer_if.sv - execute-stage multiply request/writeback bundle
//
// Purpose: groups the E-stage multiply request (StartE, OpE, operands,
// destinations, AbortE) and the multiply unit's responses (stall request,
// status, results and register-file write ports) into one bundle.
// Ports (signals):
//   StartE, OpE[1:0], SrcAE/SrcBE/SrcCE[WIDTH-1:0], RdLoE/RdHiE[3:0], AbortE
//       request side, driven by the pipeline (master)
//   StallMul, Busy, Done, ResultLo/ResultHi[WIDTH-1:0], WA1/WA2[3:0], WE1/WE2
//       response side, driven by the multiply unit (slave)
interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             StartE;
    logic [1:0]       OpE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic [WIDTH-1:0] SrcCE;
    logic [3:0]       RdLoE;
    logic [3:0]       RdHiE;
    logic             AbortE;
    logic             StallMul;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ResultLo;
    logic [WIDTH-1:0] ResultHi;
    logic [3:0]       WA1;
    logic [3:0]       WA2;
    logic             WE1;
    logic             WE2;

    modport master (
        output StartE, OpE, SrcAE, SrcBE, SrcCE, RdLoE, RdHiE, AbortE,
        input  StallMul, Busy, Done, ResultLo, ResultHi, WA1, WA2, WE1, WE2
    );

    modport slave (
        input  StartE, OpE, SrcAE, SrcBE, SrcCE, RdLoE, RdHiE, AbortE,
        output StallMul, Busy, Done, ResultLo, ResultHi, WA1, WA2, WE1, WE2
    );
endinterface

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative shift-add MUL/MLA/UMULL/SMULL unit for the E stage
//
// Purpose: one multiply every WIDTH+2 cycles (accept, WIDTH shift-add
// iterations, one DONE/writeback cycle). Holds the front of the pipeline via
// StallMul and writes low/high result words through both register-file ports.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    mul_sequencer_if.slave: request in, stall/status/result/write ports out
module mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic           clk,
    input  logic           reset,
    mul_sequencer_if.slave bus
);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MLA   = 2'b01;
    localparam logic [1:0] OP_SMULL = 2'b11;

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0]    LAST   = CNTW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [1:0]       op;
    logic [3:0]       rd_lo;
    logic [3:0]       rd_hi;
    logic [WIDTH-1:0] src_c;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             sign;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;

    logic             accept;
    logic             last_iter;
    logic             start_smull;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] res_lo_n;
    logic             long_op;

    assign accept      = (state == S_IDLE) && bus.StartE && !bus.AbortE;
    assign last_iter   = (state == S_RUN) && (cnt == LAST);
    assign start_smull = (bus.OpE == OP_SMULL);

    // Magnitudes for SMULL; the most negative value maps onto itself, which
    // is the correct unsigned magnitude.
    assign a_abs = bus.SrcAE[WIDTH-1] ? (~bus.SrcAE + ONE_W) : bus.SrcAE;
    assign b_abs = bus.SrcBE[WIDTH-1] ? (~bus.SrcBE + ONE_W) : bus.SrcBE;

    // One shift-add step: conditional add into hi keeping the carry, then
    // {carry, hi, lo} shifts right, retiring one multiplier bit from lo.
    assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign hi_n = sum[WIDTH:1];
    assign lo_n = {sum[0], lo[WIDTH-1:1]};

    // Final result formed from the last step's product so it can be
    // registered on the RUN->DONE edge.
    assign prod     = {hi_n, lo_n};
    assign prod_fix = sign ? (~prod + ONE_2W) : prod;
    assign res_lo_n = (op == OP_MLA) ? (prod_fix[WIDTH-1:0] + src_c) : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = S_RUN;
            S_RUN: begin
                if (bus.AbortE)     state_next = S_IDLE;
                else if (last_iter) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op     <= OP_MUL;
            rd_lo  <= '0;
            rd_hi  <= '0;
            src_c  <= '0;
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
            sign   <= 1'b0;
            cnt    <= '0;
            res_lo <= '0;
            res_hi <= '0;
        end else if (accept) begin
            op    <= bus.OpE;
            rd_lo <= bus.RdLoE;
            rd_hi <= bus.RdHiE;
            src_c <= bus.SrcCE;
            mcand <= start_smull ? a_abs : bus.SrcAE;
            hi    <= '0;
            lo    <= start_smull ? b_abs : bus.SrcBE;
            sign  <= start_smull && (bus.SrcAE[WIDTH-1] ^ bus.SrcBE[WIDTH-1]);
            cnt   <= '0;
        end else if (state == S_RUN) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + CNTW'(1);
            // An abort on the final iteration must not disturb the held results.
            if (last_iter && !bus.AbortE) begin
                res_lo <= res_lo_n;
                res_hi <= prod_fix[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign long_op = op[1];

    always_comb begin
        bus.StallMul = 1'b0;
        bus.Busy     = 1'b0;
        bus.Done     = 1'b0;
        bus.WE1      = 1'b0;
        bus.WE2      = 1'b0;
        bus.ResultLo = res_lo;
        bus.ResultHi = res_hi;
        bus.WA1      = rd_lo;
        bus.WA2      = rd_hi;

        // Stall already in the accept cycle so the instruction stays in E;
        // released in DONE so it advances while writing back.
        bus.StallMul = accept || (state == S_RUN);
        bus.Busy     = (state != S_IDLE);

        if (state == S_DONE) begin
            bus.Done = 1'b1;
            bus.WE2  = long_op;
            // Same destination for both halves: only the high word is written.
            bus.WE1  = !(long_op && (rd_lo == rd_hi));
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - self-checking bench for mul_sequencer
module tb_mul_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    mul_sequencer_if #(.WIDTH(32)) bus();

    mul_sequencer #(.WIDTH(32), .CNTW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'b00:   p = {32'b0, a} * {32'b0, b};
            2'b01:   p = {32'b0, a} * {32'b0, b} + {32'b0, c};
            2'b10:   p = {32'b0, a} * {32'b0, b};
            default: p = sa * sb;
        endcase
        return p;
    endfunction

    logic [63:0] exp_p;

    // Issues one multiply, checks stall behaviour, latency and writeback.
    // Returns sampling #1 after the edge that follows Done (or in the Done
    // cycle when hold=1, leaving StartE asserted).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [3:0] rl, input logic [3:0] rh,
                          input bit hold, input string tag);
        int n;
        bit stall_ok;
        logic exp_we1;
        logic exp_we2;
        exp_p   = model(op, a, b, c);
        exp_we2 = op[1];
        exp_we1 = !(op[1] && (rl == rh));
        @(negedge clk);
        bus.OpE = op; bus.SrcAE = a; bus.SrcBE = b; bus.SrcCE = c;
        bus.RdLoE = rl; bus.RdHiE = rh; bus.AbortE = 1'b0; bus.StartE = 1'b1;
        #1;
        check({tag, " stall_accept"}, {63'b0, bus.StallMul}, 64'd1);
        @(posedge clk); #1;
        if (!hold) bus.StartE = 1'b0;
        n = 0;
        stall_ok = 1'b1;
        while (!bus.Done && n < 40) begin
            if (!bus.StallMul || !bus.Busy || bus.WE1 || bus.WE2) stall_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd32);
        check({tag, " stall_run"}, {63'b0, stall_ok}, 64'd1);
        check({tag, " lo"}, {32'b0, bus.ResultLo}, {32'b0, exp_p[31:0]});
        if (op[1]) check({tag, " hi"}, {32'b0, bus.ResultHi}, {32'b0, exp_p[63:32]});
        check({tag, " we"}, {62'b0, bus.WE1, bus.WE2}, {62'b0, exp_we1, exp_we2});
        if (exp_we1) check({tag, " wa1"}, {60'b0, bus.WA1}, {60'b0, rl});
        if (exp_we2) check({tag, " wa2"}, {60'b0, bus.WA2}, {60'b0, rh});
        check({tag, " stall_done"}, {62'b0, bus.StallMul, bus.Busy}, 64'd1);
        if (!hold) begin
            @(posedge clk); #1;
            check({tag, " after_done"}, {61'b0, bus.Done, bus.WE1, bus.WE2}, 64'd0);
            check({tag, " held_lo"}, {32'b0, bus.ResultLo}, {32'b0, exp_p[31:0]});
        end
    endtask

    initial begin
        int n;
        bit seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb, rc;
        logic [3:0]  rl, rh;

        bus.StartE = 1'b0; bus.OpE = 2'b00; bus.SrcAE = '0; bus.SrcBE = '0;
        bus.SrcCE = '0; bus.RdLoE = '0; bus.RdHiE = '0; bus.AbortE = 1'b0;

        #2;
        check("reset_outs", {43'b0, bus.StallMul, bus.Busy, bus.Done, bus.WE1, bus.WE2,
                             bus.WA1, bus.WA2, 8'b0},
              64'd0);
        check("reset_results", {bus.ResultHi, bus.ResultLo}, 64'd0);
        @(negedge clk); reset = 1'b1;

        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'd2, 4'd3, 1'b0, "umull_max");
        run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 4'd1, 4'd6, 1'b0, "smull_m1");
        run_op(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h0, 4'd7, 4'd8, 1'b0, "smull_min");
        run_op(2'b01, 32'd7, 32'd6, 32'hFFFF_FFF0, 4'd5, 4'd9, 1'b0, "mla");
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0, 4'd10, 4'd11, 1'b0, "mul_wrap");
        run_op(2'b10, 32'd3, 32'd5, 32'h0, 4'd4, 4'd4, 1'b0, "umull_same_rd");
        run_op(2'b11, 32'd0, 32'hFFFF_FFFF, 32'h0, 4'd12, 4'd13, 1'b0, "smull_zero");

        // Abort in RUN.
        @(negedge clk);
        bus.OpE = 2'b10; bus.SrcAE = 32'h1234_5678; bus.SrcBE = 32'h9ABC_DEF0;
        bus.RdLoE = 4'd1; bus.RdHiE = 4'd2; bus.StartE = 1'b1;
        @(posedge clk); #1; bus.StartE = 1'b0;
        repeat (10) @(posedge clk);
        #1; bus.AbortE = 1'b1;
        @(posedge clk); #1; bus.AbortE = 1'b0;
        check("abort_idle", {61'b0, bus.Busy, bus.StallMul, bus.Done}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.Done || bus.WE1 || bus.WE2 || bus.Busy) seen = 1'b1;
        end
        check("abort_no_write", {63'b0, seen}, 64'd0);

        // Abort together with StartE in IDLE: not accepted.
        @(negedge clk); bus.StartE = 1'b1; bus.AbortE = 1'b1;
        #1; check("abort_start_stall", {63'b0, bus.StallMul}, 64'd0);
        @(posedge clk); #1;
        check("abort_start_busy", {63'b0, bus.Busy}, 64'd0);
        bus.StartE = 1'b0; bus.AbortE = 1'b0;

        // Abort during DONE is ignored: the write still happens.
        run_op(2'b00, 32'd9, 32'd9, 32'h0, 4'd3, 4'd0, 1'b1, "mul_done_abort");
        bus.StartE = 1'b0; bus.AbortE = 1'b1;
        #1; check("done_abort_we1", {62'b0, bus.WE1, bus.Done}, 64'd3);
        @(posedge clk); #1; bus.AbortE = 1'b0;
        check("done_abort_idle", {62'b0, bus.Busy, bus.Done}, 64'd0);

        // Back-to-back: StartE held through Done.
        run_op(2'b10, 32'hDEAD_BEEF, 32'h0000_1001, 32'h0, 4'd14, 4'd15, 1'b1, "b2b_first");
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.Done && n < 60);
        bus.StartE = 1'b0;
        check("b2b_spacing", 64'(n), 64'd34);
        check("b2b_second", {bus.ResultHi, bus.ResultLo}, exp_p);
        @(posedge clk); #1;
        check("b2b_idle", {62'b0, bus.Busy, bus.Done}, 64'd0);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            rc  = $urandom;
            rl  = 4'($urandom_range(0, 15));
            rh  = ($urandom_range(0, 3) == 0) ? rl : 4'($urandom_range(0, 15));
            run_op(rop, ra, rb, rc, rl, rh, 1'b0, "random");
        end

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        bus.OpE = 2'b11; bus.SrcAE = 32'hF000_0001; bus.SrcBE = 32'h7; bus.RdLoE = 4'd6;
        bus.RdHiE = 4'd7; bus.StartE = 1'b1;
        @(posedge clk); #1; bus.StartE = 1'b0;
        repeat (5) @(posedge clk);
        #3; reset = 1'b0;
        #1;
        check("rst_mid_outs", {43'b0, bus.StallMul, bus.Busy, bus.Done, bus.WE1, bus.WE2,
                               bus.WA1, bus.WA2, 8'b0},
              64'd0);
        check("rst_mid_results", {bus.ResultHi, bus.ResultLo}, 64'd0);
        @(negedge clk); reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.Done || bus.WE1 || bus.WE2 || bus.Busy) seen = 1'b1;
        end
        check("rst_no_write", {63'b0, seen}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
